// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM controller for a multicycle MIPS-subset datapath
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State
);

    // State encodings; these values are visible on State and must stay fixed.
    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] RTYPEEX = 4'd6;
    localparam logic [3:0] RTYPEWB = 4'd7;
    localparam logic [3:0] BEQEX   = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
    localparam logic [3:0] JEX     = 4'd11;

    // Opcode values recognised in DECODE / MEMADR.
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUSrcB / ALUOp / PCSource field values.
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] PC_ALURES  = 2'b00;
    localparam logic [1:0] PC_ALUOUT  = 2'b01;
    localparam logic [1:0] PC_JUMP    = 2'b10;

    logic [3:0] state;
    logic [3:0] state_next;

    // Unconditional and branch-qualified PC write terms, combined into PCWrite.
    logic       pc_write_uncond;
    logic       pc_write_branch;

    // Opcode decode, used only by the DECODE and MEMADR transitions.
    logic       op_is_mem;
    logic       op_is_lw;

    assign op_is_lw  = (Opcode == OP_LW);
    assign op_is_mem = (Opcode == OP_LW) || (Opcode == OP_SW);

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; Opcode is only consulted in DECODE and MEMADR.
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:   state_next = DECODE;
            DECODE: begin
                if (op_is_mem) begin
                    state_next = MEMADR;
                end else begin
                    case (Opcode)
                        OP_RTYPE: state_next = RTYPEEX;
                        OP_BEQ:   state_next = BEQEX;
                        OP_ADDI:  state_next = ADDIEX;
                        OP_J:     state_next = JEX;
                        default:  state_next = FETCH;
                    endcase
                end
            end
            MEMADR:  state_next = op_is_lw ? MEMRD : MEMWR;
            MEMRD:   state_next = MEMWB;
            MEMWB:   state_next = FETCH;
            MEMWR:   state_next = FETCH;
            RTYPEEX: state_next = RTYPEWB;
            RTYPEWB: state_next = FETCH;
            BEQEX:   state_next = FETCH;
            ADDIEX:  state_next = ADDIWB;
            ADDIWB:  state_next = FETCH;
            JEX:     state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Moore output decode: every strobe defaults low, each state raises its own.
    always_comb begin
        pc_write_uncond = 1'b0;
        pc_write_branch = 1'b0;
        IorD            = 1'b0;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        IRWrite         = 1'b0;
        MemtoReg        = 1'b0;
        RegDst          = 1'b0;
        RegWrite        = 1'b0;
        ALUSrcA         = 1'b0;
        ALUSrcB         = SRCB_REG;
        ALUOp           = ALU_ADD;
        PCSource        = PC_ALURES;
        case (state)
            FETCH: begin
                MemRead         = 1'b1;
                IRWrite         = 1'b1;
                ALUSrcB         = SRCB_FOUR;
                pc_write_uncond = 1'b1;
            end
            DECODE: begin
                // Precompute the branch target while the opcode is decoded.
                ALUSrcB = SRCB_IMMSH;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            RTYPEEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            RTYPEWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BEQEX: begin
                ALUSrcA         = 1'b1;
                ALUOp           = ALU_SUB;
                PCSource        = PC_ALUOUT;
                pc_write_branch = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
            end
            JEX: begin
                PCSource        = PC_JUMP;
                pc_write_uncond = 1'b1;
            end
            default: begin
                // Unused encodings drive nothing and fall back to FETCH.
            end
        endcase
    end

    // The only output that looks past State: branch taken when Zero is set.
    assign PCWrite = pc_write_uncond | (pc_write_branch & Zero);
    assign State   = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [5:0] Opcode;
    logic       Zero;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    logic [14:0] outs;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .State(State)
    );

    assign outs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                   ALUSrcA, ALUSrcB, ALUOp, PCSource};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for a state, written out from the per-state output table.
    function automatic logic [14:0] exp_outs(input logic [3:0] st, input logic z);
        logic pcw, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aop, pcs;
        pcw = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0; rdst = 0; rw = 0; srca = 0;
        srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            4'd0:  begin mrd = 1; irw = 1; srcb = 2'b01; pcw = 1; end
            4'd1:  begin srcb = 2'b11; end
            4'd2:  begin srca = 1; srcb = 2'b10; end
            4'd3:  begin iord = 1; mrd = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin iord = 1; mwr = 1; end
            4'd6:  begin srca = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rdst = 1; end
            4'd8:  begin srca = 1; aop = 2'b01; pcs = 2'b01; pcw = z; end
            4'd9:  begin srca = 1; srcb = 2'b10; end
            4'd10: begin rw = 1; end
            4'd11: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {pcw, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; Opcode = 6'b000000; Zero = 1'b0;
        tick(); tick();
        checks++;
        if (State !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", State); end
        checks++;
        if (outs !== exp_outs(4'd0, Zero)) begin errors++; $display("FAIL reset_outs: got %h expected %h", outs, exp_outs(4'd0, Zero)); end
        Opcode = 6'b100011;
        tick();
        checks++;
        if (State !== 4'd0) begin errors++; $display("FAIL reset_hold: got %0d expected 0", State); end
        reset = 1'b0;
    endtask

    // lw: 0,1,2,3,4,0; Opcode is corrupted in MEMRD and must be ignored.
    task automatic test_lw();
        logic [23:0] seq = 24'h043210;
        Opcode = 6'b100011; Zero = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (State !== seq[4*i +: 4]) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, State, seq[4*i +: 4]); end
            checks++;
            if (outs !== exp_outs(seq[4*i +: 4], Zero)) begin errors++; $display("FAIL lw_outs[%0d]: got %h expected %h", i, outs, exp_outs(seq[4*i +: 4], Zero)); end
            checks++;
            if ((MemRead && MemWrite) || (RegWrite && MemWrite)) begin errors++; $display("FAIL lw_exclusive[%0d]: got MemRead=%b MemWrite=%b RegWrite=%b expected no overlap", i, MemRead, MemWrite, RegWrite); end
            if (i == 3) Opcode = 6'b111111;
            if (i != 5) tick();
        end
    endtask

    // sw: 0,1,2,5,0; RegWrite never rises.
    task automatic test_sw();
        logic [19:0] seq = 20'h05210;
        Opcode = 6'b101011; Zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (State !== seq[4*i +: 4]) begin errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, State, seq[4*i +: 4]); end
            checks++;
            if (outs !== exp_outs(seq[4*i +: 4], Zero)) begin errors++; $display("FAIL sw_outs[%0d]: got %h expected %h", i, outs, exp_outs(seq[4*i +: 4], Zero)); end
            checks++;
            if (RegWrite !== 1'b0) begin errors++; $display("FAIL sw_regwrite[%0d]: got %b expected 0", i, RegWrite); end
            if (i != 4) tick();
        end
    endtask

    // beq taken then not taken: both pass through state 8.
    task automatic test_beq();
        logic [15:0] seq = 16'h0810;
        Opcode = 6'b000100;
        for (int r = 0; r < 2; r++) begin
            Zero = (r == 0);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (State !== seq[4*i +: 4]) begin errors++; $display("FAIL beq%0d_state[%0d]: got %0d expected %0d", r, i, State, seq[4*i +: 4]); end
                checks++;
                if (outs !== exp_outs(seq[4*i +: 4], Zero)) begin errors++; $display("FAIL beq%0d_outs[%0d]: got %h expected %h", r, i, outs, exp_outs(seq[4*i +: 4], Zero)); end
                if (i == 2) begin
                    checks++;
                    if (PCWrite !== Zero) begin errors++; $display("FAIL beq%0d_pcwrite: got %b expected %b", r, PCWrite, Zero); end
                end
                if (i != 3) tick();
            end
        end
    endtask

    // R-type, addi, j, then an unknown opcode; sequences and latencies.
    task automatic test_alu_jump();
        logic [5:0]  ops  [4] = '{6'b000000, 6'b001000, 6'b000010, 6'b111111};
        logic [19:0] seqs [4] = '{20'h07610, 20'h0A910, 20'h00B10, 20'h00010};
        int          lens [4] = '{5, 5, 4, 3};
        Zero = 1'b0;
        for (int t = 0; t < 4; t++) begin
            Opcode = ops[t];
            for (int i = 0; i < lens[t]; i++) begin
                checks++;
                if (State !== seqs[t][4*i +: 4]) begin errors++; $display("FAIL op%0d_state[%0d]: got %0d expected %0d", t, i, State, seqs[t][4*i +: 4]); end
                checks++;
                if (outs !== exp_outs(seqs[t][4*i +: 4], Zero)) begin errors++; $display("FAIL op%0d_outs[%0d]: got %h expected %h", t, i, outs, exp_outs(seqs[t][4*i +: 4], Zero)); end
                if (t == 3) begin
                    checks++;
                    if (RegWrite || MemWrite) begin errors++; $display("FAIL unknown_strobes[%0d]: got RegWrite=%b MemWrite=%b expected 0", i, RegWrite, MemWrite); end
                end
                if (i != lens[t] - 1) tick();
            end
        end
    endtask

    // Reset in MEMRD: no asynchronous effect, FETCH on the next edge.
    task automatic test_reset_mid();
        Opcode = 6'b100011; Zero = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (State !== 4'd3) begin errors++; $display("FAIL mid_reach_memrd: got %0d expected 3", State); end
        reset = 1'b1;
        #2;
        checks++;
        if (State !== 4'd3 || outs !== exp_outs(4'd3, Zero)) begin errors++; $display("FAIL mid_no_async: got state %0d outs %h expected state 3 outs %h", State, outs, exp_outs(4'd3, Zero)); end
        tick();
        checks++;
        if (State !== 4'd0) begin errors++; $display("FAIL mid_reset_state: got %0d expected 0", State); end
        checks++;
        if (MemRead !== 1'b1 || IRWrite !== 1'b1 || outs !== exp_outs(4'd0, Zero)) begin errors++; $display("FAIL mid_fetch_outs: got %h expected %h", outs, exp_outs(4'd0, Zero)); end
        reset = 1'b0;
        tick();
        checks++;
        if (State !== 4'd1) begin errors++; $display("FAIL mid_resume: got %0d expected 1", State); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_beq();
        test_alu_jump();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
